// File: rtl/layer_update_driver_if.sv
// Bundles the gradient stream, pass control and layer training signals.
// The driver connects as master; the gradient source and layer sit on slave.
interface layer_update_driver_if #(
   parameter int max_rows    = 30,
   parameter int max_columns = 64,
   parameter int datawidth   = 11
);
   localparam int NRW = $clog2(max_rows + 1);
   localparam int RSW = $clog2(max_rows);
   localparam int WW  = max_columns * datawidth;
   localparam int BW  = max_rows * 2 * datawidth;

   logic           start;
   logic [NRW-1:0] num_rows;
   logic [2:0]     lr_shift;
   logic [BW-1:0]  bias_in;
   logic           abort;
   logic           upd_valid;
   logic           upd_ready;
   logic [WW-1:0]  upd_grad;
   logic [RSW-1:0] row_sel;
   logic [WW-1:0]  weight_update;
   logic [BW-1:0]  bias_updates;
   logic           train_en;
   logic           busy;
   logic           done;
   logic           err;

   modport master (
      input  start, num_rows, lr_shift, bias_in, abort, upd_valid, upd_grad,
      output upd_ready, row_sel, weight_update, bias_updates, train_en, busy, done, err
   );

   modport slave (
      output start, num_rows, lr_shift, bias_in, abort, upd_valid, upd_grad,
      input  upd_ready, row_sel, weight_update, bias_updates, train_en, busy, done, err
   );
endinterface

// File: rtl/layer_update_driver.sv
// Training-port initiator: turns per-row gradients into scaled weight deltas and
// drives row_sel/weight_update/train_en/bias_updates with a pulse/gap per row.
module layer_update_driver #(
   parameter int max_rows    = 30,
   parameter int max_columns = 64,
   parameter int datawidth   = 11
) (
   input logic                  clk,
   input logic                  rst_overall_n,
   layer_update_driver_if.master bus
);
   localparam int NRW = $clog2(max_rows + 1);
   localparam int RSW = $clog2(max_rows);
   localparam int WW  = max_columns * datawidth;
   localparam int BW  = max_rows * 2 * datawidth;

   localparam logic [NRW-1:0] MAX_N = NRW'(max_rows);
   localparam logic signed [datawidth+1:0] W_MAX = {3'b000, {(datawidth-1){1'b1}}};
   localparam logic signed [datawidth+1:0] W_MIN = {3'b111, {(datawidth-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_PULSE,
      S_GAP,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [RSW-1:0] r_q, r_d;
   logic [NRW-1:0] num_rows_q, num_rows_d;
   logic [2:0]     lr_shift_q, lr_shift_d;
   logic [BW-1:0]  bias_cap_q, bias_cap_d;
   logic [WW-1:0]  weight_q, weight_d;
   logic [BW-1:0]  bias_upd_q, bias_upd_d;
   logic           train_en_q, train_en_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [WW-1:0]  scaled_w;

   // Round-half-up right shift, then negate; only -(-2^(dw-1)) at s=0 can overflow.
   function automatic logic [datawidth-1:0] scale_delta(input logic [datawidth-1:0] g,
                                                       input logic [2:0] s);
      logic signed [datawidth+1:0] ext;
      logic signed [datawidth+1:0] rnd;
      logic signed [datawidth+1:0] q;
      logic signed [datawidth+1:0] neg;
      ext = {{2{g[datawidth-1]}}, g};
      rnd = '0;
      if (s != 3'd0) begin
         rnd = (datawidth+2)'(1) << (s - 3'd1);
      end
      q   = (ext + rnd) >>> s;
      neg = -q;
      if (neg > W_MAX) begin
         return W_MAX[datawidth-1:0];
      end else if (neg < W_MIN) begin
         return W_MIN[datawidth-1:0];
      end
      return neg[datawidth-1:0];
   endfunction

   always_comb begin
      scaled_w = '0;
      for (int unsigned c = 0; c < max_columns; c++) begin
         scaled_w[c*datawidth +: datawidth] =
            scale_delta(bus.upd_grad[c*datawidth +: datawidth], lr_shift_q);
      end
   end

   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      num_rows_d = num_rows_q;
      lr_shift_d = lr_shift_q;
      bias_cap_d = bias_cap_q;
      weight_d   = weight_q;
      bias_upd_d = bias_upd_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               num_rows_d = bus.num_rows;
               lr_shift_d = bus.lr_shift;
               bias_cap_d = bus.bias_in;
               r_d        = '0;
               err_d      = 1'b0;
               if (bus.num_rows == '0 || bus.num_rows > MAX_N) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bus.upd_valid) begin
               weight_d   = scaled_w;
               bias_upd_d = (r_q == '0) ? bias_cap_q : '0;
               state_d    = S_PULSE;
            end
         end
         S_PULSE: state_d = S_GAP;
         S_GAP: begin
            bias_upd_d = '0;
            if (NRW'(r_q) == num_rows_q - NRW'(1)) begin
               state_d = S_DONE;
            end else begin
               r_d     = r_q + RSW'(1);
               state_d = S_WAIT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (bus.abort && state_q != S_IDLE) begin
         state_d    = S_IDLE;
         bias_upd_d = '0;
      end

      // Strobes are flopped from the next state so they line up with state_q.
      train_en_d = (state_d == S_PULSE);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_overall_n) begin
      if (!rst_overall_n) begin
         state_q    <= S_IDLE;
         r_q        <= '0;
         num_rows_q <= '0;
         lr_shift_q <= '0;
         bias_cap_q <= '0;
         weight_q   <= '0;
         bias_upd_q <= '0;
         train_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         num_rows_q <= num_rows_d;
         lr_shift_q <= lr_shift_d;
         bias_cap_q <= bias_cap_d;
         weight_q   <= weight_d;
         bias_upd_q <= bias_upd_d;
         train_en_q <= train_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.upd_ready     = (state_q == S_WAIT);
   assign bus.row_sel       = r_q;
   assign bus.weight_update = weight_q;
   assign bus.bias_updates  = bias_upd_q;
   assign bus.train_en      = train_en_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
endmodule
